ones_mod4_rr_sched: RTL and testbench

Shares one mod-4 ones-count engine between NUM_REQ requesters, each streaming 2-bit symbols framed by a last flag. A round-robin scheduler grants at most one symbol per cycle. Each requester has its own saved residue context, so frames may interleave freely. On each frame end the block emits one result: requester id, final residue, and whether the total ones count is a multiple of 4.

---
 rtl/ones_mod4_rr_sched_pkg.sv | 32 +++
 rtl/ones_mod4_rr_sched_arbiter.sv | 35 +++
 rtl/ones_mod4_rr_sched.sv | 152 +++++++++++++++
 tb/tb_ones_mod4_rr_sched.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ones_mod4_rr_sched_pkg.sv
// ----------------------------------------------------------------------------
// ones_mod4_pkg
// Shared types and helpers for the shared mod-4 ones-count scheduler.
//   residue_t    : 2-bit running ones count modulo 4
//   out_state_t  : output slot state (EMPTY / FULL)
//   sym_weight() : number of ones in a 2-bit symbol
// ----------------------------------------------------------------------------
package ones_mod4_pkg;

    typedef logic [1:0] residue_t;

    localparam logic ENC_EMPTY = 1'b0;
    localparam logic ENC_FULL  = 1'b1;

    typedef enum logic {
        ST_EMPTY = ENC_EMPTY,
        ST_FULL  = ENC_FULL
    } out_state_t;

    // A symbol holds two bits, so its weight is 0, 1 or 2.
    function automatic residue_t sym_weight(input logic [1:0] sym);
        residue_t w;
        case (sym)
            2'b00:   w = 2'd0;
            2'b01:   w = 2'd1;
            2'b10:   w = 2'd1;
            default: w = 2'd2;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ones_mod4_rr_sched_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter_n
// Combinational round-robin arbiter. Grants the first asserted request found
// when searching upward from ptr with wrap-around.
//   req [N]  : request vector
//   en       : arbitration enable; gnt is zero when low
//   ptr [PW] : index where the search starts (must be < N)
//   gnt [N]  : one-hot grant, or zero when nothing is granted
// ----------------------------------------------------------------------------
module rr_arbiter_n #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic w_found;

    // Walk the requests starting at ptr; the first hit wins and masks the
    // rest. The modulo folds the search back to index 0 after N-1.
    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (en && !w_found && req[(int'(ptr) + k) % N]) begin
                gnt[(int'(ptr) + k) % N] = 1'b1;
                w_found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ones_mod4_rr_sched.sv
// ----------------------------------------------------------------------------
// ones_mod4_rr_sched
// One mod-4 ones-count engine shared by NUM_REQ symbol streams. A round-robin
// arbiter picks at most one 2-bit symbol per cycle; each requester keeps its
// own residue context so frames may interleave. Every frame end produces one
// result through a single-entry output register with valid/ready handshake.
//   clk, rst            : clock, synchronous active-high reset
//   clr                 : clears all contexts and the round-robin pointer
//   req_valid/last [N]  : per-requester symbol valid and end-of-frame flag
//   req_data [2N]       : symbols, requester i on bits [2i+1:2i]
//   req_ready [N]       : one-hot grant
//   res_valid/ready     : result handshake
//   res_id/residue/mult4: requester id, ones count mod 4, residue == 0
// ----------------------------------------------------------------------------
module ones_mod4_rr_sched
    import ones_mod4_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [2*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic [1:0]           res_residue,
    output logic                 res_mult4
);

    residue_t         r_ctx [NUM_REQ];
    logic [ID_W-1:0]  r_rr_ptr;
    out_state_t       r_state;
    out_state_t       w_state_next;
    logic [ID_W-1:0]  r_res_id;
    residue_t         r_res_residue;
    logic             r_res_mult4;

    logic             w_slot_free;
    logic             w_arb_en;
    logic [NUM_REQ-1:0] w_gnt;
    logic             w_accept;
    logic [ID_W-1:0]  w_gid;
    logic [1:0]       w_sym;
    logic             w_last;
    residue_t         w_sum;
    logic             w_new_result;
    logic [ID_W-1:0]  w_ptr_next;

    // The output register can take a new result if it is empty now or is
    // being drained this very cycle, which is what allows back-to-back
    // results. clr suppresses all grants for its cycle.
    assign w_slot_free = (r_state == ST_EMPTY) || res_ready;
    assign w_arb_en    = w_slot_free && !clr;

    rr_arbiter_n #(
        .N  (NUM_REQ),
        .PW (ID_W)
    ) u_arb (
        .req (req_valid),
        .en  (w_arb_en),
        .ptr (r_rr_ptr),
        .gnt (w_gnt)
    );

    assign req_ready = w_gnt;
    assign w_accept  = |w_gnt;

    // Turn the one-hot grant into an index and pick out the granted
    // requester's symbol and last flag.
    always_comb begin
        w_gid  = '0;
        w_sym  = 2'b00;
        w_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gid  = ID_W'(i);
                w_sym  = req_data[2*i +: 2];
                w_last = req_last[i];
            end
        end
    end

    // The 2-bit addition wraps naturally, giving the mod-4 residue.
    assign w_sum        = residue_t'(r_ctx[w_gid] + sym_weight(w_sym));
    assign w_new_result = w_accept && w_last;
    assign w_ptr_next   = (w_gid == ID_W'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;

    // Output slot state: filled by a frame end, emptied by a drain unless a
    // new frame end refills it in the same cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_new_result) w_state_next = ST_FULL;
            ST_FULL:  if (res_ready && !w_new_result) w_state_next = ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Per-requester contexts and round-robin pointer. A frame end returns the
    // context to zero so the requester's next frame starts fresh. Nothing
    // changes when no symbol is accepted (idle or stalled).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_ctx[i] <= '0;
            end
        end else if (clr) begin
            r_rr_ptr <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_ctx[i] <= '0;
            end
        end else if (w_accept) begin
            r_rr_ptr     <= w_ptr_next;
            r_ctx[w_gid] <= w_last ? residue_t'(2'd0) : w_sum;
        end
    end

    // Result payload. It is loaded only on a frame end and otherwise holds,
    // so it stays stable while the consumer backpressures.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_id      <= '0;
            r_res_residue <= '0;
            r_res_mult4   <= 1'b0;
        end else if (w_new_result) begin
            r_res_id      <= w_gid;
            r_res_residue <= w_sum;
            r_res_mult4   <= (w_sum == 2'd0);
        end
    end

    assign res_valid   = (r_state == ST_FULL);
    assign res_id      = r_res_id;
    assign res_residue = r_res_residue;
    assign res_mult4   = r_res_mult4;

endmodule

// File: tb/tb_ones_mod4_rr_sched.sv
// ----------------------------------------------------------------------------
// tb_ones_mod4_rr_sched
// Directed bench for ones_mod4_rr_sched with NUM_REQ = 4. Inputs are driven
// just after the rising edge; grants are looked at a moment later and
// registered results one step after the following rising edge.
// ----------------------------------------------------------------------------
module tb_ones_mod4_rr_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clr;
    logic [NUM_REQ-1:0]   req_valid;
    logic [2*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [ID_W-1:0]      res_id;
    logic [1:0]           res_residue;
    logic                 res_mult4;

    int checks = 0;
    int errors = 0;

    // Packed view of the result: {valid, id, residue, mult4}.
    logic [5:0] resBus;
    assign resBus = {res_valid, res_id, res_residue, res_mult4};

    ones_mod4_rr_sched #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_residue (res_residue),
        .res_mult4   (res_mult4)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task idleInputs;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        clr       = 1'b0;
    endtask

    task applyStimulus(input int i, input logic [1:0] d, input logic l);
        req_valid[i]       = 1'b1;
        req_data[2*i +: 2] = d;
        req_last[i]        = l;
    endtask

    task test_reset;
        rst       = 1'b1;
        res_ready = 1'b0;
        idleInputs();
        tick();
        tick();
        checks++;
        if (resBus !== 6'b0_00_00_0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", resBus, 6'b0_00_00_0);
        end
        rst = 1'b0;
    endtask

    task test_single_frame;
        logic [1:0] syms [3];
        syms[0] = 2'b11; syms[1] = 2'b11; syms[2] = 2'b00;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            idleInputs();
            applyStimulus(0, syms[c], c == 2);
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL single_grant%0d: got %b expected %b", c, req_ready, 4'b0001);
            end
            tick();
        end
        idleInputs();
        #1;
        checks++;
        if (resBus !== 6'b1_00_00_1) begin
            errors++;
            $display("[TB] FAIL single_result: got %b expected %b", resBus, 6'b1_00_00_1);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drain: got %b expected 0", res_valid);
        end
    endtask

    task test_interleave;
        logic [3:0] expG [4];
        logic [1:0] d0 [4];
        logic [1:0] d1 [4];
        logic       l0 [4];
        logic       l1 [4];
        logic       v0 [4];
        expG[0] = 4'b0001; expG[1] = 4'b0010; expG[2] = 4'b0001; expG[3] = 4'b0010;
        d0[0] = 2'b01; d0[1] = 2'b01; d0[2] = 2'b01; d0[3] = 2'b01;
        l0[0] = 1'b0;  l0[1] = 1'b1;  l0[2] = 1'b1;  l0[3] = 1'b1;
        v0[0] = 1'b1;  v0[1] = 1'b1;  v0[2] = 1'b1;  v0[3] = 1'b0;
        d1[0] = 2'b11; d1[1] = 2'b11; d1[2] = 2'b11; d1[3] = 2'b11;
        l1[0] = 1'b0;  l1[1] = 1'b0;  l1[2] = 1'b1;  l1[3] = 1'b1;
        // A clr cycle with a request present must not grant; it also
        // returns the pointer to 0.
        idleInputs();
        applyStimulus(0, 2'b01, 1'b0);
        clr = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL clr_no_grant: got %b expected %b", req_ready, 4'b0000);
        end
        tick();
        for (int c = 0; c < 4; c++) begin
            idleInputs();
            if (v0[c]) applyStimulus(0, d0[c], l0[c]);
            applyStimulus(1, d1[c], l1[c]);
            #1;
            checks++;
            if (req_ready !== expG[c]) begin
                errors++;
                $display("[TB] FAIL interleave_grant%0d: got %b expected %b", c, req_ready, expG[c]);
            end
            if (c == 3) begin
                checks++;
                if (resBus !== 6'b1_00_10_0) begin
                    errors++;
                    $display("[TB] FAIL interleave_res0: got %b expected %b", resBus, 6'b1_00_10_0);
                end
            end
            tick();
        end
        idleInputs();
        #1;
        checks++;
        if (resBus !== 6'b1_01_00_1) begin
            errors++;
            $display("[TB] FAIL interleave_res1: got %b expected %b", resBus, 6'b1_01_00_1);
        end
        tick();
    endtask

    task test_wrap;
        int         r;
        int         p;
        int         s;
        logic [3:0] expG;
        logic [5:0] expR;
        // Pointer is 2 here; a clr cycle returns it to 0.
        idleInputs();
        clr = 1'b1;
        tick();
        // Each requester sends 11, 01, 11(last): 2, 3, then 3+2 wraps to 1.
        for (int c = 0; c < 12; c++) begin
            r = c / 4;
            p = c % 4;
            idleInputs();
            for (int i = 0; i < NUM_REQ; i++) begin
                s = r + ((i < p) ? 1 : 0);
                case (s)
                    0: applyStimulus(i, 2'b11, 1'b0);
                    1: applyStimulus(i, 2'b01, 1'b0);
                    2: applyStimulus(i, 2'b11, 1'b1);
                    default: ;
                endcase
            end
            #1;
            expG = 4'b0001 << p;
            checks++;
            if (req_ready !== expG) begin
                errors++;
                $display("[TB] FAIL wrap_grant%0d: got %b expected %b", c, req_ready, expG);
            end
            if (c >= 9) begin
                expR = {1'b1, ID_W'(p - 1), 2'b01, 1'b0};
                checks++;
                if (resBus !== expR) begin
                    errors++;
                    $display("[TB] FAIL wrap_result%0d: got %b expected %b", c, resBus, expR);
                end
            end
            tick();
        end
        idleInputs();
        #1;
        checks++;
        if (resBus !== 6'b1_11_01_0) begin
            errors++;
            $display("[TB] FAIL wrap_result_last: got %b expected %b", resBus, 6'b1_11_01_0);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_drain: got %b expected 0", res_valid);
        end
    endtask

    task test_backpressure;
        res_ready = 1'b1;
        idleInputs();
        applyStimulus(0, 2'b10, 1'b1);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL bp_first_grant: got %b expected %b", req_ready, 4'b0001);
        end
        tick();
        idleInputs();
        res_ready = 1'b0;
        applyStimulus(1, 2'b11, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL bp_stall_grant%0d: got %b expected %b", c, req_ready, 4'b0000);
            end
            checks++;
            if (resBus !== 6'b1_00_01_0) begin
                errors++;
                $display("[TB] FAIL bp_stable%0d: got %b expected %b", c, resBus, 6'b1_00_01_0);
            end
            tick();
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL bp_release_grant: got %b expected %b", req_ready, 4'b0010);
        end
        tick();
        idleInputs();
        #1;
        checks++;
        if (resBus !== 6'b1_01_10_0) begin
            errors++;
            $display("[TB] FAIL bp_back_to_back: got %b expected %b", resBus, 6'b1_01_10_0);
        end
        tick();
    endtask

    task test_clr_mid_frame;
        // Pointer is 2 here.
        idleInputs();
        applyStimulus(2, 2'b11, 1'b0);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL clr_first_grant: got %b expected %b", req_ready, 4'b0100);
        end
        tick();
        idleInputs();
        applyStimulus(2, 2'b01, 1'b1);
        clr = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL clr_cycle_grant: got %b expected %b", req_ready, 4'b0000);
        end
        tick();
        clr = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL clr_after_grant: got %b expected %b", req_ready, 4'b0100);
        end
        tick();
        idleInputs();
        #1;
        checks++;
        if (resBus !== 6'b1_10_01_0) begin
            errors++;
            $display("[TB] FAIL clr_result: got %b expected %b", resBus, 6'b1_10_01_0);
        end
        tick();
    endtask

    task test_reset_mid;
        // Pointer is 3 here. Leave ctx3 = 2, pointer = 2 and a pending result.
        idleInputs();
        applyStimulus(3, 2'b11, 1'b0);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL rstmid_grant3: got %b expected %b", req_ready, 4'b1000);
        end
        tick();
        idleInputs();
        applyStimulus(1, 2'b11, 1'b1);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL rstmid_grant1: got %b expected %b", req_ready, 4'b0010);
        end
        tick();
        idleInputs();
        res_ready = 1'b0;
        #1;
        checks++;
        if (resBus !== 6'b1_01_10_0) begin
            errors++;
            $display("[TB] FAIL rstmid_pending: got %b expected %b", resBus, 6'b1_01_10_0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (resBus !== 6'b0_00_00_0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got %b expected %b", resBus, 6'b0_00_00_0);
        end
        // Pointer back at 0 means requester 1 wins over requester 3.
        res_ready = 1'b1;
        applyStimulus(1, 2'b01, 1'b1);
        applyStimulus(3, 2'b10, 1'b1);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL rstmid_ptr_grant: got %b expected %b", req_ready, 4'b0010);
        end
        tick();
        req_valid[1] = 1'b0;
        #1;
        checks++;
        if (resBus !== 6'b1_01_01_0) begin
            errors++;
            $display("[TB] FAIL rstmid_res1: got %b expected %b", resBus, 6'b1_01_01_0);
        end
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL rstmid_grant_req3: got %b expected %b", req_ready, 4'b1000);
        end
        tick();
        idleInputs();
        #1;
        checks++;
        if (resBus !== 6'b1_11_01_0) begin
            errors++;
            $display("[TB] FAIL rstmid_res3: got %b expected %b", resBus, 6'b1_11_01_0);
        end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_drain: got %b expected 0", res_valid);
        end
    endtask

    // Scenario sequence; each scenario leaves the block idle for the next.
    initial begin
        rst       = 1'b1;
        res_ready = 1'b0;
        idleInputs();
        test_reset();
        test_single_frame();
        test_interleave();
        test_wrap();
        test_backpressure();
        test_clr_mid_frame();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
